// File: rtl/multicycle_alu.sv
// Iterative ALU: single-cycle logic/arithmetic ops, shift-add multiply and restoring
// divide, with a valid/ready handshake on both the request and the result side.
package alu_pkg;
  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLL    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;
endpackage

module multicycle_alu
  import alu_pkg::*;
#(
  parameter int REG_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [4:0]           i_op,
  input  logic [REG_WIDTH-1:0] i_op1,
  input  logic [REG_WIDTH-1:0] i_op2,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [REG_WIDTH-1:0] o_result,
  output logic                 o_zero
);
  localparam int SHAMT_W = $clog2(REG_WIDTH);
  localparam logic [SHAMT_W-1:0]   CNT_LAST = SHAMT_W'(REG_WIDTH - 1);
  localparam logic [REG_WIDTH-1:0] MOST_NEG = {1'b1, {(REG_WIDTH-1){1'b0}}};
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [SHAMT_W-1:0]     cnt_q, cnt_d;
  logic [4:0]             op_q, op_d;
  logic [REG_WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic                   neg_q, neg_d;
  logic [REG_WIDTH-1:0]   result_q, result_d;
  logic                   zero_q, zero_d;

  logic                   is_mul, sgn1, sgn2;
  logic [REG_WIDTH:0]     mul_sum, rem_sh, rem_diff;
  logic [REG_WIDTH-1:0]   step_hi, step_lo, final_res;
  logic [2*REG_WIDTH-1:0] prod, prod_fin;

  function automatic logic [REG_WIDTH-1:0] cond_neg(input logic neg,
                                                    input logic [REG_WIDTH-1:0] v);
    cond_neg = neg ? -v : v;
  endfunction

  function automatic logic [REG_WIDTH-1:0] alu_simple(input logic [4:0] op,
                                                      input logic [REG_WIDTH-1:0] a,
                                                      input logic [REG_WIDTH-1:0] b);
    logic signed [REG_WIDTH-1:0] sa;
    logic signed [REG_WIDTH-1:0] sb;
    logic [SHAMT_W-1:0]          sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = b[SHAMT_W-1:0];
    case (op)
      OP_ADD:  alu_simple = a + b;
      OP_SUB:  alu_simple = a - b;
      OP_AND:  alu_simple = a & b;
      OP_OR:   alu_simple = a | b;
      OP_XOR:  alu_simple = a ^ b;
      OP_SLL:  alu_simple = a << sh;
      OP_SRL:  alu_simple = a >> sh;
      OP_SRA:  alu_simple = $unsigned(sa >>> sh);
      OP_SLT:  alu_simple = {{(REG_WIDTH-1){1'b0}}, sa < sb};
      OP_SLTU: alu_simple = {{(REG_WIDTH-1){1'b0}}, a < b};
      default: alu_simple = '0;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    neg_d    = neg_q;
    result_d = result_q;
    sgn1     = 1'b0;
    sgn2     = 1'b0;

    // One iteration: hi:lo is the product/partial-remainder pair, lo the shifting operand
    is_mul   = (op_q >= OP_MUL) && (op_q <= OP_MULHU);
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh   = {hi_q, lo_q[REG_WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    if (is_mul) begin
      step_hi = mul_sum[REG_WIDTH:1];
      step_lo = {mul_sum[0], lo_q[REG_WIDTH-1:1]};
    end else begin
      step_hi = rem_diff[REG_WIDTH] ? rem_sh[REG_WIDTH-1:0] : rem_diff[REG_WIDTH-1:0];
      step_lo = {lo_q[REG_WIDTH-2:0], ~rem_diff[REG_WIDTH]};
    end
    prod     = {step_hi, step_lo};
    prod_fin = neg_q ? -prod : prod;
    case (op_q)
      OP_MUL:                       final_res = prod_fin[REG_WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fin[2*REG_WIDTH-1:REG_WIDTH];
      OP_DIV, OP_DIVU:              final_res = cond_neg(neg_q, step_lo);
      default:                      final_res = cond_neg(neg_q, step_hi);
    endcase

    case (state_q)
      S_IDLE: begin
        if (i_valid && !i_flush) begin
          op_d    = i_op;
          cnt_d   = '0;
          hi_d    = '0;
          state_d = S_DONE;
          if (i_op >= OP_MUL && i_op <= OP_MULHU) begin
            sgn1    = (i_op != OP_MULHU);
            sgn2    = (i_op == OP_MUL) || (i_op == OP_MULH);
            lo_d    = cond_neg(sgn1 & i_op1[REG_WIDTH-1], i_op1);
            b_d     = cond_neg(sgn2 & i_op2[REG_WIDTH-1], i_op2);
            neg_d   = (sgn1 & i_op1[REG_WIDTH-1]) ^ (sgn2 & i_op2[REG_WIDTH-1]);
            state_d = S_BUSY;
          end else if (i_op >= OP_DIV && i_op <= OP_REMU) begin
            sgn1 = (i_op == OP_DIV) || (i_op == OP_REM);
            // Divide-by-zero and signed overflow complete immediately
            if (i_op2 == '0) begin
              result_d = (i_op == OP_DIV || i_op == OP_DIVU) ? '1 : i_op1;
            end else if (sgn1 && i_op1 == MOST_NEG && i_op2 == '1) begin
              result_d = (i_op == OP_DIV) ? i_op1 : '0;
            end else begin
              lo_d    = cond_neg(sgn1 & i_op1[REG_WIDTH-1], i_op1);
              b_d     = cond_neg(sgn1 & i_op2[REG_WIDTH-1], i_op2);
              neg_d   = (i_op == OP_DIV) ? (i_op1[REG_WIDTH-1] ^ i_op2[REG_WIDTH-1])
                                         : (sgn1 & i_op1[REG_WIDTH-1]);
              state_d = S_BUSY;
            end
          end else begin
            result_d = alu_simple(i_op, i_op1, i_op2);
          end
        end
      end
      S_BUSY: begin
        if (i_flush) begin
          state_d = S_IDLE;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + SHAMT_W'(1);
          if (cnt_q == CNT_LAST) begin
            result_d = final_res;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (i_flush || i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = (state_q == S_DONE);
  assign o_result = result_q;
  assign o_zero   = zero_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: directed literal cases plus randomized ops, all checked
// every cycle against a transaction-level reference model using 64-bit arithmetic.
`timescale 1ns/1ps
module tb_multicycle_alu;
  import alu_pkg::*;
  localparam int W = 32;

  logic          i_clk = 1'b0;
  logic          i_rst, i_valid, o_ready, i_flush, o_valid, i_ready, o_zero;
  logic [4:0]    i_op;
  logic [W-1:0]  i_op1, i_op2, o_result;
  int            n_cmp = 0;
  int            n_fail = 0;

  always #5 i_clk = ~i_clk;

  multicycle_alu #(.REG_WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_op1(i_op1), .i_op2(i_op2), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_zero(o_zero)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result and latency of one operation
  function automatic void ref_op(input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] res,
                                 output int lat);
    longint      sa, sb, sp;
    logic [63:0] ua, ub, up;
    bit          ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    lat = 1;
    res = '0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SLL:  res = a << b[4:0];
      OP_SRL:  res = a >> b[4:0];
      OP_SRA:  begin sp = sa >>> b[4:0]; res = sp[31:0]; end
      OP_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: res = (a < b) ? 32'd1 : 32'd0;
      OP_MUL:    begin sp = sa * sb; res = sp[31:0]; lat = 33; end
      OP_MULH:   begin sp = sa * sb; res = sp[63:32]; lat = 33; end
      OP_MULHSU: begin sp = sa * longint'(ub); res = sp[63:32]; lat = 33; end
      OP_MULHU:  begin up = ua * ub; res = up[63:32]; lat = 33; end
      OP_DIV: begin
        if (b == 0) res = '1;
        else if (ovf) res = a;
        else begin sp = sa / sb; res = sp[31:0]; lat = 33; end
      end
      OP_DIVU: begin
        if (b == 0) res = '1;
        else begin up = ua / ub; res = up[31:0]; lat = 33; end
      end
      OP_REM: begin
        if (b == 0) res = a;
        else if (ovf) res = '0;
        else begin sp = sa % sb; res = sp[31:0]; lat = 33; end
      end
      OP_REMU: begin
        if (b == 0) res = a;
        else begin up = ua % ub; res = up[31:0]; lat = 33; end
      end
      default: res = '0;
    endcase
  endfunction

  // Model: m_rem < 0 idle, > 0 edges left before the result, 0 result presented
  int          m_rem = -1;
  int          m_lat;
  logic [31:0] m_res = '0;
  bit          m_rstres = 1'b0;
  bit          m_live = 1'b0;

  always @(posedge i_clk) begin
    if (i_rst) begin
      m_rem = -1; m_rstres = 1'b1; m_live = 1'b1;
    end else if (m_rem < 0) begin
      if (i_valid && !i_flush) begin
        ref_op(i_op, i_op1, i_op2, m_res, m_lat);
        m_rem = m_lat - 1;
        m_rstres = 1'b0;
      end
    end else if (m_rem > 0) begin
      if (i_flush) m_rem = -1;
      else m_rem--;
    end else if (i_flush || i_ready) begin
      m_rem = -1;
    end
  end

  always @(negedge i_clk) begin
    if (m_live) begin
      chk("o_ready", o_ready, m_rem < 0);
      chk("o_valid", o_valid, m_rem == 0);
      if (m_rem == 0) begin
        chk("o_result", o_result, m_res);
        chk("o_zero", o_zero, m_res == 0);
      end
      if (m_rstres) begin
        chk("rst_result", o_result, 0);
        chk("rst_zero", o_zero, 1);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic accept(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int g = 0;
    while (!o_ready && g < 200) begin tick(); g++; end
    if (!o_ready) chk("ready_timeout", o_ready, 1);
    i_valid = 1'b1; i_op = op; i_op1 = a; i_op2 = b;
    tick();
    i_valid = 1'b0; i_op = 5'($urandom); i_op1 = $urandom; i_op2 = $urandom;
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 1;
    while (!o_valid && lat < 100) begin tick(); lat++; end
    chk({name, "_valid"}, o_valid, 1);
  endtask

  task automatic finish_op(input bit use_lit, input logic [31:0] lit, input int lit_lat,
                           input int hold, input string name);
    int lat;
    wait_valid(name, lat);
    if (use_lit) begin
      chk({name, "_lat"}, lat, lit_lat);
      chk({name, "_res"}, o_result, lit);
      chk({name, "_zero"}, o_zero, lit == 0);
    end
    repeat (hold) tick();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lit, input int lit_lat, input string name);
    accept(op, a, b);
    finish_op(1'b1, lit, lit_lat, $urandom_range(0, 2), name);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: rnd_val = 32'h0;
      1: rnd_val = 32'h1;
      2: rnd_val = 32'hFFFF_FFFF;
      3: rnd_val = 32'h8000_0000;
      4: rnd_val = 32'h7FFF_FFFF;
      default: rnd_val = $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [4:0] op;
    i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
    i_op = '0; i_op1 = '0; i_op2 = '0;
    repeat (3) tick();
    i_rst = 1'b0;
    chk("post_rst_ready", o_ready, 1);
    chk("post_rst_valid", o_valid, 0);
    chk("post_rst_result", o_result, 0);
    chk("post_rst_zero", o_zero, 1);

    run(OP_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE, 1,  "sub");
    run(OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'h0,         1,  "sltu");
    run(OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'h1,         1,  "slt");
    run(OP_SRA,  32'h8000_0010, 32'd36,        32'hF800_0001, 1,  "sra");
    run(OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh");
    run(OP_MULHU,32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    run(OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, "mul");
    run(OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div");
    run(OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem");
    run(OP_DIVU, 32'd7,         32'd0,         32'hFFFF_FFFF, 1,  "divu_by0");
    run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
    run(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1,  "rem_ovf");
    run(5'd31,   32'd123,       32'd456,       32'h0,         1,  "badop");

    // Result held while downstream stalls; a request on the release edge is ignored
    accept(OP_DIVU, 32'd1000, 32'd7);
    wait_valid("hold", lat);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_res", o_result, 32'd142);
      chk("hold_ready", o_ready, 0);
    end
    i_ready = 1'b1; i_valid = 1'b1; i_op = OP_ADD; i_op1 = 32'd1; i_op2 = 32'd1;
    tick();
    i_ready = 1'b0; i_valid = 1'b0;
    chk("release_ready", o_ready, 1);
    chk("release_valid", o_valid, 0);

    // Flush wins over a simultaneous request
    i_valid = 1'b1; i_flush = 1'b1; i_op = OP_ADD; i_op1 = 32'd9; i_op2 = 32'd9;
    tick();
    i_valid = 1'b0; i_flush = 1'b0;
    chk("flush_idle_valid", o_valid, 0);

    // Flush in the middle of a multiply
    accept(OP_MUL, 32'd1234, 32'd5678);
    repeat (4) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("flush_valid", o_valid, 0);
    chk("flush_ready", o_ready, 1);
    run(OP_ADD, 32'd2, 32'd3, 32'd5, 1, "add_after_flush");

    // Reset in the middle of a divide
    accept(OP_DIV, 32'd100, 32'd7);
    repeat (11) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_result", o_result, 0);
    chk("midrst_zero", o_zero, 1);
    chk("midrst_ready", o_ready, 1);

    for (int n = 0; n < 400; n++) begin
      op = 5'($urandom_range(0, 18));
      if (op == 5'd18) op = 5'($urandom_range(18, 31));
      accept(op, rnd_val(), rnd_val());
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(0, 3)) tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
      end else begin
        finish_op(1'b0, '0, 0, $urandom_range(0, 3), "rnd");
      end
    end

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter REG_WIDTH, default 32: operand and result width, a power of two, at least 8.
REQ-002 The block SHALL have localparam SHAMT_W = log2(REG_WIDTH): shift-amount width.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_valid, input, 1 bit: the request is valid.
REQ-006 The block SHALL have port o_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port i_op, input, 5 bits: operation code from alu_pkg, one of ADD SUB AND OR XOR SLL SRL SRA SLT SLTU MUL MULH MULHSU MULHU DIV DIVU REM REMU.
REQ-008 The block SHALL have ports i_op1 and i_op2, input, REG_WIDTH bits each: the already-selected operands.
REQ-009 The block SHALL have port i_flush, input, 1 bit: abort the operation in flight.
REQ-010 The block SHALL have port o_valid, output, 1 bit: the result is valid.
REQ-011 The block SHALL have port i_ready, input, 1 bit: downstream accepts the result.
REQ-012 The block SHALL have port o_result, output, REG_WIDTH bits: the registered result.
REQ-013 The block SHALL have port o_zero, output, 1 bit: o_result == 0, registered with the result.

Function
REQ-014 States SHALL be IDLE, BUSY, DONE; o_ready = 1 only in IDLE.
REQ-015 A request SHALL be accepted on a rising edge with i_valid & o_ready; operands and op are captured at acceptance, and later input changes have no effect.
REQ-016 Single-cycle ops (ADD..SLTU) SHALL go IDLE -> DONE; o_valid is asserted the cycle after acceptance (latency 1).
REQ-017 ADD/SUB SHALL be modulo 2^REG_WIDTH.
REQ-018 Shifts SHALL use i_op2[SHAMT_W-1:0]; SRA is arithmetic.
REQ-019 SLT/SLTU SHALL return 1 or 0, zero-extended, by signed or unsigned comparison.
REQ-020 MUL* SHALL use an iterative shift-add over operand magnitudes: IDLE -> BUSY for exactly REG_WIDTH cycles -> DONE; o_valid is asserted REG_WIDTH+1 cycles after acceptance.
REQ-021 MUL SHALL return the low REG_WIDTH bits of the product; MULH, MULHSU, MULHU SHALL return the high REG_WIDTH bits of the 2*REG_WIDTH-bit signed x signed, signed x unsigned, and unsigned x unsigned products respectively.
REQ-022 DIV* SHALL use a restoring radix-2 divider with the same BUSY length and latency as MUL*.
REQ-023 Signed quotients SHALL truncate toward zero; the remainder takes the sign of the dividend.
REQ-024 Divide by zero SHALL be resolved without entering BUSY (latency 1): quotient = all ones, remainder = dividend, signed or unsigned.
REQ-025 Signed overflow (DIV/REM with most-negative / -1) SHALL be resolved without entering BUSY (latency 1): quotient = dividend, remainder = 0.
REQ-026 In DONE, o_valid = 1 and o_result/o_zero SHALL hold stable until i_ready = 1; the DONE & i_ready edge returns to IDLE.
REQ-027 A new request SHALL NOT be accepted on the same edge that completes DONE; back-to-back throughput is one op per 2 cycles minimum.
REQ-028 i_flush = 1 SHALL force the next state to IDLE and clear o_valid on the next edge, from BUSY or DONE, with no result delivered.
REQ-029 i_flush SHALL take priority over acceptance and over i_ready.
REQ-030 An i_op value outside the enumerated set SHALL be treated as single-cycle and return result 0.

Reset
REQ-031 i_rst = 1 at a rising edge SHALL force state IDLE, o_valid = 0, o_result = 0, o_zero = 1, and clear the iteration counter and datapath registers, regardless of state.
REQ-032 Reset SHALL have priority over i_flush and the handshake; a multi-cycle operation in flight is discarded.
REQ-033 o_ready SHALL be 1 in the first cycle after reset is released.

Verification (REG_WIDTH = 32)
REQ-034 SUB, op1 = 5, op2 = 7 -> o_valid after 1 cycle, o_result = 0xFFFFFFFE, o_zero = 0; SLTU of 0xFFFFFFFF, 1 -> 0; SLT of the same operands -> 1.
REQ-035 MULH, 0x80000000 x 0x80000000 -> o_valid at cycle 33, result 0x40000000; MULHU of 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL of the same operands -> 0x00000001.
REQ-036 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 7 / 0 -> 0xFFFFFFFF at latency 1; DIV 0x80000000 / -1 -> 0x80000000 at latency 1.
REQ-037 DIVU accepted, i_ready held 0 for 10 cycles after o_valid -> o_result stable and o_ready = 0 throughout; the i_ready pulse returns the block to IDLE.
REQ-038 MUL accepted, i_flush = 1 at cycle 5 -> o_valid never asserted, o_ready = 1 next cycle; a following ADD 2 + 3 -> 5.
REQ-039 DIV in flight, i_rst = 1 at cycle 12 -> o_valid = 0, o_result = 0, o_zero = 1, o_ready = 1 after release.
